// File: rtl/disk_responder.sv
// disk_responder: UART sector-transfer responder serving 512-byte sectors
// from a byte-wide synchronous sector memory.
module disk_responder #(
    parameter int SECTOR_BITS = 8,
    parameter int TIMEOUT     = 1000000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_valid_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   tx_ready_i,
    output logic                   tx_start_o,
    output logic [7:0]             tx_data_o,
    output logic [SECTOR_BITS+8:0] mem_addr_o,
    output logic                   mem_we_o,
    output logic [7:0]             mem_wdata_o,
    input  logic [7:0]             mem_rdata_i,
    output logic                   busy_o,
    output logic                   xfer_done_o,
    output logic                   xfer_write_o,
    output logic                   err_o
);
    typedef enum logic [2:0] {IDLE, ACK, FETCH, LOAD, SEND, RECV, BYE} state_e;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e                   state_q;
    logic [1:0]               cnt_q;
    logic [23:0]              req_q;
    logic [SECTOR_BITS-1:0]   sector_q;
    logic                     ok_q;
    logic                     wr_q;
    logic [8:0]               idx_q;
    logic [TW-1:0]            tmo_q;
    logic [7:0]               tx_data_q;
    logic [SECTOR_BITS+8:0]   mem_addr_q;
    logic                     mem_we_q;
    logic [7:0]               mem_wdata_q;
    logic                     done_q;
    logic                     err_q;
    logic [31:0]              req_d;
    logic                     req_ok_d;
    logic                     tmo_run_d;
    logic                     tmo_hit_d;

    always_comb begin
        req_d     = {rx_data_i, req_q};
        req_ok_d  = req_d[30] && (req_d[29:SECTOR_BITS] == '0);
        tmo_run_d = (state_q == IDLE && cnt_q != 2'd0) || state_q == RECV || state_q == BYE;
        tmo_hit_d = tmo_run_d && !rx_valid_i && tmo_q == TW'(TIMEOUT - 1);
    end

    assign tx_start_o   = (state_q == ACK || state_q == SEND) && tx_ready_i;
    assign tx_data_o    = tx_data_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign busy_o       = state_q != IDLE;
    assign xfer_done_o  = done_q;
    assign xfer_write_o = wr_q;
    assign err_o        = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            sector_q    <= '0;
            ok_q        <= 1'b0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            tmo_q       <= '0;
            tx_data_q   <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            // Every state change happens on rx_valid, from a non-counting state, or on timeout.
            tmo_q    <= (rx_valid_i || !tmo_run_d) ? '0 : tmo_q + TW'(1);
            if (tmo_hit_d) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                err_q   <= 1'b1;
                tmo_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (rx_valid_i) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q != 2'd3) begin
                            req_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
                        end else begin
                            state_q   <= ACK;
                            sector_q  <= req_d[SECTOR_BITS-1:0];
                            wr_q      <= req_d[31];
                            ok_q      <= req_ok_d;
                            tx_data_q <= {8{req_ok_d}};
                        end
                    end
                    ACK: if (tx_ready_i) begin
                        idx_q   <= '0;
                        state_q <= !ok_q ? IDLE : wr_q ? RECV : FETCH;
                        if (ok_q && !wr_q) mem_addr_q <= {sector_q, 9'd0};
                    end
                    FETCH: state_q <= LOAD;
                    LOAD: begin
                        tx_data_q <= mem_rdata_i;
                        state_q   <= SEND;
                    end
                    SEND: if (tx_ready_i) begin
                        state_q    <= &idx_q ? BYE : FETCH;
                        idx_q      <= idx_q + 9'd1;
                        mem_addr_q <= {sector_q, idx_q + 9'd1};
                    end
                    RECV: if (rx_valid_i) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= rx_data_i;
                        mem_addr_q  <= {sector_q, idx_q};
                        idx_q       <= idx_q + 9'd1;
                        state_q     <= &idx_q ? BYE : RECV;
                    end
                    BYE: if (rx_valid_i) begin
                        done_q  <= rx_data_i == 8'hff;
                        err_q   <= rx_data_i != 8'hff;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_disk_responder.sv
// tb_disk_responder: table-driven and randomized checks of disk_responder
// against a sector-store reference model.
module tb_disk_responder;
    localparam int SB = 8;
    localparam int TO = 300;
    localparam int AW = SB + 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          tx_ready = 1'b1;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = '0;
    logic          busy;
    logic          xfer_done;
    logic          xfer_write;
    logic          err;

    disk_responder #(.SECTOR_BITS(SB), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_ready_i(tx_ready), .tx_start_o(tx_start), .tx_data_o(tx_data),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .xfer_done_o(xfer_done),
        .xfer_write_o(xfer_write), .err_o(err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_err = 0;
    bit rnd_ready = 1'b0;
    bit prev_start = 1'b0;
    logic [7:0]    tx_q[$];
    logic [AW-1:0] wa_q[$];
    logic [7:0]    wd_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] ack_of(input logic [31:0] instr);
        return (instr[30] && instr[29:SB] == '0) ? 8'hff : 8'h00;
    endfunction

    always @(negedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_data);
            chk("tx_start_ready", {31'd0, tx_ready}, 32'd1);
            chk("tx_start_gap", {31'd0, prev_start}, 32'd0);
        end
        prev_start = tx_start;
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (xfer_done) n_done++;
        if (err) n_err++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_req(input logic [31:0] instr, input int gap);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, gap)) tick();
            send_byte(instr[8*i +: 8]);
        end
    endtask

    task automatic wait_tx(input int n, input int lim);
        while (tx_q.size() < n && lim > 0) begin
            tick();
            lim--;
        end
    endtask

    task automatic clear_logs();
        tx_q.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic do_req(input logic [31:0] instr, input logic [7:0] exp_ack, input logic [7:0] bye,
                          input int gap, input int stall_at, input bit rnd);
        logic [SB-1:0] sec;
        logic [8:0]    kk;
        logic [7:0]    d;
        int nmis, lim, n, d0, e0;
        bit saved;
        sec = instr[SB-1:0];
        clear_logs();
        d0 = n_done;
        e0 = n_err;
        send_req(instr, gap);
        wait_tx(1, 50);
        chk("ack", tx_q.size() > 0 ? {24'd0, tx_q[0]} : 32'hdead, {24'd0, exp_ack});
        chk("xfer_write", {31'd0, xfer_write}, {31'd0, instr[31]});
        if (exp_ack != 8'hff) begin
            repeat (3) tick();
            chk("inv_busy", {31'd0, busy}, 32'd0);
            chk("inv_nowrite", wa_q.size(), 32'd0);
            chk("inv_txcount", tx_q.size(), 32'd1);
            return;
        end
        if (!instr[31]) begin
            lim = 20000;
            while (tx_q.size() < 513 && lim > 0) begin
                if (stall_at > 0 && tx_q.size() == stall_at) begin
                    n = tx_q.size();
                    saved = rnd_ready;
                    rnd_ready = 1'b0;
                    tx_ready = 1'b0;
                    repeat (50) tick();
                    chk("stall_hold", tx_q.size(), n);
                    chk("stall_busy", {31'd0, busy}, 32'd1);
                    tx_ready = 1'b1;
                    rnd_ready = saved;
                    stall_at = 0;
                end
                tick();
                lim--;
            end
            chk("rd_count", tx_q.size(), 32'd513);
            nmis = 0;
            for (int k = 0; k < 512 && k + 1 < tx_q.size(); k++) begin
                kk = k[8:0];
                if (tx_q[k+1] !== ref_mem[{sec, kk}]) nmis++;
            end
            chk("rd_data", nmis, 32'd0);
        end else begin
            for (int k = 0; k < 512; k++) begin
                kk = k[8:0];
                d = rnd ? 8'($urandom) : (8'ha5 ^ kk[7:0]);
                ref_mem[{sec, kk}] = d;
                repeat ($urandom_range(0, gap)) tick();
                send_byte(d);
                if (k == 0) begin
                    chk("we_latency", {31'd0, mem_we}, 32'd1);
                    chk("we_addr0", {15'd0, mem_addr}, {15'd0, sec, 9'd0});
                end
            end
            tick();
            chk("wr_count", wa_q.size(), 32'd512);
            nmis = 0;
            for (int k = 0; k < wa_q.size(); k++) begin
                kk = k[8:0];
                if (wa_q[k] !== {sec, kk} || wd_q[k] !== ref_mem[{sec, kk}]) nmis++;
            end
            chk("wr_data", nmis, 32'd0);
        end
        chk("bye_busy", {31'd0, busy}, 32'd1);
        send_byte(bye);
        chk("done", {31'd0, xfer_done}, {31'd0, bye == 8'hff});
        chk("err", {31'd0, err}, {31'd0, bye != 8'hff});
        chk("end_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("one_pulse", n_done - d0 + n_err - e0, 32'd1);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  ack;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c, e0, n;
        logic [31:0] instr;
        logic [7:0]  bye;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 8'(i);
            ref_mem[i] = 8'(i);
        end
        tbl[0] = '{32'h4000_0003, 8'hff};
        tbl[1] = '{32'h0000_0003, 8'h00};
        tbl[2] = '{32'h4000_0100, 8'h00};
        tbl[3] = '{32'hC000_0005, 8'hff};
        tbl[4] = '{32'h6000_0001, 8'h00};
        tbl[5] = '{32'h8000_0002, 8'h00};
        tbl[6] = '{32'h4000_0005, 8'hff};

        #1;
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_done", {31'd0, xfer_done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_write", {31'd0, xfer_write}, 32'd0);
        chk("rst_addr", {15'd0, mem_addr}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) do_req(tbl[i].instr, tbl[i].ack, 8'hff, 1, 0, 1'b0);

        // Bad goodbye after a read stalled mid-stream.
        do_req(32'h4000_0003, 8'hff, 8'h00, 0, 100, 1'b0);

        // Write abandoned after 100 bytes.
        clear_logs();
        e0 = n_err;
        send_req(32'hC000_0007, 0);
        wait_tx(1, 50);
        chk("to_ack", tx_q.size() > 0 ? {24'd0, tx_q[0]} : 32'hdead, 32'hff);
        for (int k = 0; k < 100; k++) begin
            bye = 8'($urandom);
            ref_mem[{8'd7, 9'(k)}] = bye;
            send_byte(bye);
        end
        c = 0;
        while (!err && c < TO + 50) begin
            tick();
            c++;
        end
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_window", {31'd0, c >= TO - 2 && c <= TO + 2}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("to_writes", wa_q.size(), 32'd100);
        chk("to_one_err", n_err - e0, 32'd1);

        // Partial request abandoned in IDLE, then a full request must start from byte 0.
        e0 = n_err;
        send_byte(8'h07);
        send_byte(8'h00);
        c = 0;
        while (!err && c < TO + 50) begin
            tick();
            c++;
        end
        chk("idle_to_err", {31'd0, err}, 32'd1);
        tick();
        do_req(32'h4000_0007, 8'hff, 8'hff, 1, 0, 1'b0);

        // Reset in the middle of a read.
        clear_logs();
        send_req(32'h4000_0003, 0);
        wait_tx(201, 2000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", {31'd0, tx_start}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_data", {24'd0, tx_data}, 32'd0);
        chk("mid_rst_addr", {15'd0, mem_addr}, 32'd0);
        chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        n = tx_q.size();
        repeat (5) tick();
        chk("post_rst_quiet", tx_q.size(), n);
        chk("post_rst_nowrite", wa_q.size(), 32'd0);
        do_req(32'h4000_0003, 8'hff, 8'hff, 1, 0, 1'b0);

        // Randomized traffic against the reference model.
        rnd_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            instr = {1'($urandom_range(0, 1)), 1'b1, 22'd0, 8'($urandom_range(0, 255))};
            if ($urandom_range(0, 4) == 0) instr[8 + $urandom_range(0, 21)] = 1'b1;
            if ($urandom_range(0, 5) == 0) instr[30] = 1'b0;
            bye = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 254)) : 8'hff;
            do_req(instr, ack_of(instr), bye, 1, 0, 1'b1);
        end
        rnd_ready = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
